program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Boot-time stage directly upstream of the A09 CPU.
- Accepts a byte stream (UART/host) over a valid/ready handshake and assembles it into DataWidth words.
- Writes those words sequentially into the CPU memory starting at address 0, and holds the CPU in reset until the image is loaded.
- Owns the memory write port and the CPU reset line while loading; after DONE it releases both and stops driving memory.

Parameters:
- DataWidth, 16, memory word width; must be a multiple of 8.
- AddrWidth, 8, memory address width; maximum image is 2^AddrWidth words.

Ports:
- Clk  input  1  system clock
- Reset  input  1  synchronous, active-high reset
- Start  input  1  one-cycle pulse; begins a load from IDLE or DONE
- Rx_Data  input  8  incoming byte
- Rx_Valid  input  1  Rx_Data valid
- Rx_Ready  output  1  loader accepts a byte this cycle
- Mem_Addr  output  AddrWidth  write address
- Mem_DOut  output  DataWidth  write data
- Mem_Wr  output  1  memory write strobe
- Mem_En  output  1  memory enable; high only with Mem_Wr
- CPU_Reset  output  1  drives the CPU Reset input; high = CPU held
- Busy  output  1  load in progress
- Error  output  1  sticky load failure

Behaviour:
- All outputs are registered.
- Reset values:
  - CPU_Reset=1; all other outputs 0.
  - State=IDLE; byte counter, word counter, address and length are all 0.
- Byte transfer: a byte is accepted when Rx_Valid && Rx_Ready at the Clk edge.
  - Bytes are big-endian: the first byte goes to word[DataWidth-1:DataWidth-8].
  - BPW = DataWidth/8 bytes make one word.
- States:
  - IDLE: Rx_Ready=0, CPU_Reset=1. On Start go to LEN and set Busy=1.
  - LEN: Rx_Ready=1. Collect one word as length N.
    - N=0 goes to DONE (CHECK if CHECKSUM_EN).
    - N > 2^AddrWidth goes to ERROR.
    - Otherwise go to DATA with Mem_Addr=0.
  - DATA: Rx_Ready=1 while collecting.
    - On the BPW-th accepted byte: the next cycle is WRITE.
  - WRITE: one cycle, with Rx_Ready=0, Mem_Wr=1, Mem_En=1, Mem_DOut=assembled word, Mem_Addr=current address.
    - The cycle after WRITE: address increments and the word counter increments.
    - If the counter reaches N go to DONE (CHECK if CHECKSUM_EN); else return to DATA.
  - DONE: Rx_Ready=0, Busy=0.
    - CPU_Reset falls to 0 one cycle after DONE is entered.
    - Start returns to LEN and re-asserts CPU_Reset=1 in the same cycle the state changes.
  - ERROR: Rx_Ready=0, Busy=0, Error=1, CPU_Reset=1.
    - Only Reset or Start leaves this state. Start clears Error and goes to LEN.
- Address wrap: N = 2^AddrWidth writes to address 2^AddrWidth-1 last. The address register wrapping to 0 afterwards is harmless and is not an error.
- Throughput: each word costs BPW accepted cycles plus 1 WRITE cycle. Stalls on Rx_Valid=0 are unlimited and hold all state.
- Start pulses are ignored outside IDLE, DONE and ERROR.
- Reset mid-operation: the next cycle gives full reset values. The partial image stays in memory, and CPU_Reset=1.
- Start and Reset asserted together: Reset wins.

Optional Feature:
- Macro: PROGRAM_LOADER_CHECKSUM_EN.
- When defined:
  - After the N data words, state CHECK collects one extra word C.
  - The loader keeps a running DataWidth-bit sum S (mod 2^DataWidth) of the length word and all data words.
  - S + C == 0 goes to DONE; otherwise go to ERROR with CPU_Reset held at 1.
  - C is never written to memory.
- When undefined:
  - There is no CHECK state and no sum register.
  - Last WRITE goes straight to DONE.

Test Plan:
- Basic load: Reset, Start, send 00 02 12 34 AB CD with Rx_Valid continuous.
  - Required: Mem_Wr pulses at addr0=0x1234 and addr1=0xABCD.
  - Rx_Ready is low during each WRITE.
  - CPU_Reset goes 1→0 one cycle after DONE; Busy=0.
- Zero length: Start, send 00 00.
  - Required: no Mem_Wr pulse, DONE reached, CPU_Reset=0. (With the checksum macro defined, first send checksum 00 00.)
- Oversize: with AddrWidth=8, send length 01 01 (257).
  - Required: ERROR, Error=1, Rx_Ready=0, CPU_Reset=1, no writes.
- Stall and mid-load reset: send length 00 03, then byte 55, then Rx_Valid=0 for 10 cycles.
  - Required: state is held.
  - Then pulse Reset. Required: IDLE, Error=0, CPU_Reset=1, Busy=0, and a subsequent Start restarts at address 0.
- Checksum (macro defined): load length 0001, data 0x0010, then checksum 0xFFEF.
  - Required: DONE.
  - Repeat with checksum 0xFFEE. Required: ERROR with CPU_Reset=1.
  - Then Start clears Error.
- Reload from DONE: after a good load, pulse Start.
  - Required: CPU_Reset=1 the same cycle LEN is entered.
  - A new 1-word image overwrites addr0.

Source files
------------

// File: rtl/program_loader.sv
// program_loader: boot-time byte-stream loader that fills A09 CPU memory from address 0
// and holds the CPU in reset until the image is in. Define PROGRAM_LOADER_CHECKSUM_EN for a trailing checksum word.
module program_loader #(
  parameter int DataWidth = 16,
  parameter int AddrWidth = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [7:0]           Rx_Data,
  input  logic                 Rx_Valid,
  output logic                 Rx_Ready,
  output logic [AddrWidth-1:0] Mem_Addr,
  output logic [DataWidth-1:0] Mem_DOut,
  output logic                 Mem_Wr,
  output logic                 Mem_En,
  output logic                 CPU_Reset,
  output logic                 Busy,
  output logic                 Error
);

  localparam int unsigned BPW = DataWidth / 8;
  localparam int unsigned BCW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int unsigned LW  = (DataWidth > AddrWidth + 1) ? DataWidth : AddrWidth + 1;

  localparam logic [BCW-1:0]     LAST_BYTE = BCW'(BPW - 1);
  localparam logic [BCW-1:0]     BYTE_ONE  = BCW'(1);
  localparam logic [LW-1:0]      MAX_LEN   = LW'(1) << AddrWidth;
  localparam logic [AddrWidth:0] CNT_ONE   = (AddrWidth + 1)'(1);
  localparam logic [AddrWidth-1:0] ADDR_ONE = AddrWidth'(1);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERROR
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    , S_CHECK
`endif
  } state_t;

  // State that follows the last image word (or a zero-length header).
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam state_t S_AFTER_IMAGE = S_CHECK;
`else
  localparam state_t S_AFTER_IMAGE = S_DONE;
`endif

  state_t               state;
  logic [BCW-1:0]       byte_cnt;
  logic [DataWidth-1:0] word_q;
  logic [DataWidth-1:0] word_next;
  logic [AddrWidth:0]   len_q;
  logic [AddrWidth:0]   word_cnt;
  logic [AddrWidth:0]   word_cnt_next;
  logic [LW-1:0]        len_word;
  logic                 accept;
  logic                 last_byte;
  logic                 start_ok;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [DataWidth-1:0] sum_q;
  logic [DataWidth-1:0] sum_chk;
`endif

  always_comb begin
    accept        = Rx_Valid && Rx_Ready;
    last_byte     = accept && (byte_cnt == LAST_BYTE);
    // Big-endian assembly: earlier bytes shift toward the MSBs.
    word_next     = (word_q << 8) | DataWidth'(Rx_Data);
    len_word      = LW'(word_next);
    word_cnt_next = word_cnt + CNT_ONE;
    start_ok      = Start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    sum_chk       = sum_q + word_next;
`endif
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= S_IDLE;
      byte_cnt  <= '0;
      word_q    <= '0;
      len_q     <= '0;
      word_cnt  <= '0;
      Mem_Addr  <= '0;
      Mem_DOut  <= '0;
      Mem_Wr    <= 1'b0;
      Mem_En    <= 1'b0;
      Rx_Ready  <= 1'b0;
      CPU_Reset <= 1'b1;
      Busy      <= 1'b0;
      Error     <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      if (accept) begin
        word_q   <= word_next;
        byte_cnt <= last_byte ? '0 : byte_cnt + BYTE_ONE;
      end

      if (start_ok) begin
        state     <= S_LEN;
        Rx_Ready  <= 1'b1;
        Busy      <= 1'b1;
        Error     <= 1'b0;
        CPU_Reset <= 1'b1;
        byte_cnt  <= '0;
        word_cnt  <= '0;
        Mem_Addr  <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        sum_q     <= '0;
`endif
      end else begin
        case (state)
          S_IDLE: ;

          S_LEN: begin
            if (last_byte) begin
              len_q    <= len_word[AddrWidth:0];
              word_cnt <= '0;
              Mem_Addr <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
              sum_q    <= word_next;
`endif
              if (len_word == '0) begin
                state    <= S_AFTER_IMAGE;
                Rx_Ready <= CK_EN;
                Busy     <= CK_EN;
              end else if (len_word > MAX_LEN) begin
                state    <= S_ERROR;
                Rx_Ready <= 1'b0;
                Busy     <= 1'b0;
                Error    <= 1'b1;
              end else begin
                state    <= S_DATA;
              end
            end
          end

          S_DATA: begin
            if (last_byte) begin
              state    <= S_WRITE;
              Rx_Ready <= 1'b0;
              Mem_Wr   <= 1'b1;
              Mem_En   <= 1'b1;
              Mem_DOut <= word_next;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
              sum_q    <= sum_q + word_next;
`endif
            end
          end

          S_WRITE: begin
            Mem_Wr   <= 1'b0;
            Mem_En   <= 1'b0;
            Mem_DOut <= '0;
            // A full 2^AddrWidth image wraps the address back to 0 here; that is harmless.
            Mem_Addr <= Mem_Addr + ADDR_ONE;
            word_cnt <= word_cnt_next;
            if (word_cnt_next == len_q) begin
              state    <= S_AFTER_IMAGE;
              Rx_Ready <= CK_EN;
              Busy     <= CK_EN;
            end else begin
              state    <= S_DATA;
              Rx_Ready <= 1'b1;
            end
          end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
          S_CHECK: begin
            if (last_byte) begin
              Rx_Ready <= 1'b0;
              Busy     <= 1'b0;
              if (sum_chk == '0) begin
                state <= S_DONE;
              end else begin
                state <= S_ERROR;
                Error <= 1'b1;
              end
            end
          end
`endif

          S_DONE: CPU_Reset <= 1'b0;

          S_ERROR: ;

          default: begin
            state    <= S_IDLE;
            Rx_Ready <= 1'b0;
            Busy     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: directed boot scenarios plus randomized images with stalls,
// checked against an image-level model of the expected memory writes and final status.
`timescale 1ns/1ps
module tb_program_loader;
  localparam int DW = 16;
  localparam int AW = 8;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          Start;
  logic [7:0]    Rx_Data;
  logic          Rx_Valid;
  logic          Rx_Ready;
  logic [AW-1:0] Mem_Addr;
  logic [DW-1:0] Mem_DOut;
  logic          Mem_Wr;
  logic          Mem_En;
  logic          CPU_Reset;
  logic          Busy;
  logic          Error;

  always #5 Clk = ~Clk;

  program_loader #(.DataWidth(DW), .AddrWidth(AW)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start),
    .Rx_Data(Rx_Data), .Rx_Valid(Rx_Valid), .Rx_Ready(Rx_Ready),
    .Mem_Addr(Mem_Addr), .Mem_DOut(Mem_DOut), .Mem_Wr(Mem_Wr), .Mem_En(Mem_En),
    .CPU_Reset(CPU_Reset), .Busy(Busy), .Error(Error)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           exp_wr[$];
  logic [DW-1:0] img[$];
  int unsigned   n_cmp = 0;
  int unsigned   n_bad = 0;
  bit            stall_en = 1'b0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: every memory write must match the next expected write, with the byte port closed.
  always @(negedge Clk) begin
    wr_t e;
    if (Mem_Wr || Mem_En) begin
      check("mem_en_tracks_wr", 32'(Mem_En), 32'(Mem_Wr));
      check("rx_ready_in_write", 32'(Rx_Ready), 32'd0);
      if (exp_wr.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected at %0t", Mem_Addr, Mem_DOut, $time);
      end else begin
        e = exp_wr.pop_front();
        check("wr_addr", 32'(Mem_Addr), 32'(e.addr));
        check("wr_data", 32'(Mem_DOut), 32'(e.data));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int unsigned t = 0;
    if (stall_en) begin
      while ($urandom_range(0, 3) == 0) begin
        Rx_Valid = 1'b0;
        Start    = ($urandom_range(0, 5) == 0);
        @(negedge Clk);
        Start    = 1'b0;
      end
    end
    Rx_Valid = 1'b1;
    Rx_Data  = b;
    while (!Rx_Ready && t < 20) begin
      @(negedge Clk);
      t++;
    end
    if (!Rx_Ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL rx_ready_timeout: byte 0x%02h not accepted within 20 cycles", b);
    end else begin
      @(negedge Clk);
    end
    Rx_Valid = 1'b0;
  endtask

  task automatic send_word(input logic [DW-1:0] w);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic start_pulse();
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    check("start_busy", 32'(Busy), 32'd1);
    check("start_rx_ready", 32'(Rx_Ready), 32'd1);
    check("start_cpu_reset", 32'(CPU_Reset), 32'd1);
    check("start_error_clear", 32'(Error), 32'd0);
  endtask

  task automatic wait_outcome(input bit exp_err);
    int unsigned t = 0;
    while (Busy && t < 40) begin
      @(negedge Clk);
      t++;
    end
    check("busy_after_load", 32'(Busy), 32'd0);
    check("error_flag", 32'(Error), 32'(exp_err));
    check("rx_ready_after_load", 32'(Rx_Ready), 32'd0);
    check("cpu_reset_on_entry", 32'(CPU_Reset), 32'd1);
    @(negedge Clk);
    check("cpu_reset_settled", 32'(CPU_Reset), exp_err ? 32'd1 : 32'd0);
    check("writes_outstanding", 32'(exp_wr.size()), 32'd0);
  endtask

  // Reference model: a valid image of n words lands at addresses 0..n-1 in order;
  // oversize headers produce no writes and an error.
  task automatic do_load(input logic [DW-1:0] n, input bit use_img, input bit chk_bad);
    logic [DW-1:0] s;
    logic [DW-1:0] d;
    bit            exp_err;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [DW-1:0] c;
`endif
    start_pulse();
    send_word(n);
    if (32'(n) > (32'd1 << AW)) begin
      exp_err = 1'b1;
    end else begin
      s = n;
      for (int unsigned i = 0; i < 32'(n); i++) begin
        d = use_img ? img[i] : DW'($urandom);
        s = s + d;
        exp_wr.push_back({AW'(i), d});
        send_word(d);
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      c = chk_bad ? (DW'(0) - s - DW'(1)) : (DW'(0) - s);
      send_word(c);
      exp_err = chk_bad;
`else
      exp_err = 1'b0;
`endif
    end
    wait_outcome(exp_err);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] n;
    Reset    = 1'b1;
    Start    = 1'b0;
    Rx_Valid = 1'b0;
    Rx_Data  = 8'h00;
    repeat (2) @(negedge Clk);
    check("rst_cpu_reset", 32'(CPU_Reset), 32'd1);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_error", 32'(Error), 32'd0);
    check("rst_rx_ready", 32'(Rx_Ready), 32'd0);
    check("rst_mem", {7'd0, Mem_Wr, Mem_En, Mem_Addr, Mem_DOut}, 32'd0);
    Reset = 1'b0;
    @(negedge Clk);

    // Basic two-word image, bytes 00 02 12 34 AB CD.
    img = '{16'h1234, 16'hABCD};
    do_load(16'd2, 1'b1, 1'b0);

    // Reload from DONE overwrites address 0.
    img = '{16'h5A5A};
    do_load(16'd1, 1'b1, 1'b0);

    do_load(16'd0, 1'b0, 1'b0);
    do_load(16'h0101, 1'b0, 1'b0);
    do_load(16'd256, 1'b0, 1'b0);

    // Stall mid-word, then reset; the half-received word must be discarded.
    start_pulse();
    send_word(16'd3);
    send_byte(8'h55);
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      check("stall_hold", {27'd0, Rx_Ready, Busy, CPU_Reset, Error, Mem_Wr}, 32'b11100);
    end
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check("midreset_status", {28'd0, Busy, Error, CPU_Reset, Rx_Ready}, 32'b0010);
    img = '{16'hC0DE};
    do_load(16'd1, 1'b1, 1'b0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    img = '{16'h0010};
    do_load(16'd1, 1'b1, 1'b0);
    do_load(16'd1, 1'b1, 1'b1);
`endif

    // Start and Reset together: Reset wins.
    Start = 1'b1;
    Reset = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    Reset = 1'b0;
    check("start_vs_reset", {29'd0, Busy, Rx_Ready, CPU_Reset}, 32'b001);

    stall_en = 1'b1;
    repeat (25) begin
      case ($urandom_range(0, 9))
        0:       n = 16'd0;
        1:       n = 16'd256;
        2:       n = DW'($urandom_range(257, 65535));
        default: n = DW'($urandom_range(1, 8));
      endcase
      do_load(n, 1'b0, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
